// File: rtl/if_stage_if.sv
// if_stage_if: IF<->ID handshake plus inst SRAM port bundle.
// if_adef exists only when IF_ADEF_EN is defined.
interface if_stage_if;
  logic        id_allowin;
  logic [32:0] id_to_if_bus;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
`ifdef IF_ADEF_EN
  logic        if_adef;
  modport master (
    input  id_allowin, id_to_if_bus, inst_sram_rdata,
    output if_to_id_valid, if_to_id_bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata, if_adef
  );
  modport slave (
    output id_allowin, id_to_if_bus, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata, if_adef
  );
`else
  modport master (
    input  id_allowin, id_to_if_bus, inst_sram_rdata,
    output if_to_id_valid, if_to_id_bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata
  );
  modport slave (
    output id_allowin, id_to_if_bus, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_bus, inst_sram_en, inst_sram_we,
           inst_sram_addr, inst_sram_wdata
  );
`endif
endinterface

// File: rtl/if_stage.sv
// if_stage: LoongArch IF stage with PC, branch redirect and a one-entry instruction buffer.
// Optional macro IF_ADEF_EN adds misaligned-fetch reporting on if_adef.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input logic        clk,
  input logic        resetn,
  if_stage_if.master bus
);
  typedef enum logic {EMPTY, FULL} buf_state_t;
  buf_state_t  state, state_nx;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] buf_inst;
  logic [31:0] nextpc;
  logic [31:0] raw_inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic        fs_allowin;
  logic        capture;
  logic        fault;
  assign {br_taken, br_target} = bus.id_to_if_bus;
  assign to_fs_valid = resetn;
  assign nextpc      = br_taken ? br_target : fs_pc + 32'd4;
  assign fs_allowin  = ~fs_valid | bus.id_allowin | br_taken;
  // Capture only while the fetch is stalled, so the SRAM is never re-requested that cycle.
  assign capture     = (state == EMPTY) & fs_valid & ~bus.id_allowin & ~br_taken;
  assign raw_inst    = (state == FULL) ? buf_inst : bus.inst_sram_rdata;
  always_comb begin
    state_nx = (state == EMPTY) ? (capture ? FULL : EMPTY)
                                : ((bus.id_allowin | br_taken) ? EMPTY : FULL);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      buf_inst <= 32'h0;
    end else begin
      state    <= state_nx;
      if (capture) buf_inst <= bus.inst_sram_rdata;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      fs_pc    <= nextpc;
    end
  end
`ifdef IF_ADEF_EN
  logic fs_adef;
  assign fault = |nextpc[1:0];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fs_adef <= 1'b0;
    else if (fs_allowin) fs_adef <= fault;
  end
  assign bus.if_adef      = fs_valid & ~br_taken & fs_adef;
  assign bus.if_to_id_bus = {fs_adef ? 32'h0 : raw_inst, fs_pc};
`else
  assign fault            = 1'b0;
  assign bus.if_to_id_bus = {raw_inst, fs_pc};
`endif
  assign bus.if_to_id_valid  = fs_valid & ~br_taken;
  assign bus.inst_sram_en    = to_fs_valid & fs_allowin & ~fault;
  assign bus.inst_sram_addr  = nextpc;
  assign bus.inst_sram_we    = 4'b0;
  assign bus.inst_sram_wdata = 32'b0;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table plus randomized run against an instruction-stream model.
module tb_if_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  if_stage_if bus_i();
  if_stage dut (.clk(clk), .resetn(resetn), .bus(bus_i));
  int checks = 0;
  int errors = 0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h1c000000) ? 32'h02800421 : ({a[15:0], a[31:16]} ^ 32'hc3c3a5a5);
  endfunction
  // Read data is garbage unless a request was accepted the cycle before.
  always @(posedge clk)
    bus_i.inst_sram_rdata <= bus_i.inst_sram_en ? mem(bus_i.inst_sram_addr) : $urandom;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic al, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus_i.id_allowin = al;
    bus_i.id_to_if_bus = {br, tgt};
    @(negedge clk);
  endtask
  typedef struct {
    logic al; logic br; logic [31:0] tgt;
    logic v; logic [31:0] pc; logic en; logic [31:0] addr;
  } vec_t;
  vec_t vt[$];
  task automatic add(input logic al, input logic br, input logic [31:0] tgt,
                     input logic v, input logic [31:0] pc, input logic en, input logic [31:0] addr);
    vec_t r;
    r.al = al; r.br = br; r.tgt = tgt; r.v = v; r.pc = pc; r.en = en; r.addr = addr;
    vt.push_back(r);
  endtask
  logic        al, br;
  logic [31:0] tgt, exp_pc;
  initial begin
    bus_i.id_allowin = 1'b1;
    bus_i.id_to_if_bus = 33'h0;
    add(1, 0, 0,            0, 0,            1, 32'h1c000000);
    add(0, 0, 0,            1, 32'h1c000000, 0, 0);
    add(0, 0, 0,            1, 32'h1c000000, 0, 0);
    add(0, 0, 0,            1, 32'h1c000000, 0, 0);
    add(1, 0, 0,            1, 32'h1c000000, 1, 32'h1c000004);
    add(1, 0, 0,            1, 32'h1c000004, 1, 32'h1c000008);
    add(1, 0, 0,            1, 32'h1c000008, 1, 32'h1c00000c);
    add(1, 1, 32'h1c000100, 0, 0,            1, 32'h1c000100);
    add(1, 0, 0,            1, 32'h1c000100, 1, 32'h1c000104);
    add(0, 0, 0,            1, 32'h1c000104, 0, 0);
    add(0, 1, 32'h1c000200, 0, 0,            1, 32'h1c000200);
    add(1, 0, 0,            1, 32'h1c000200, 1, 32'h1c000204);
    add(1, 0, 0,            1, 32'h1c000204, 1, 32'h1c000208);
    add(1, 1, 32'hfffffffc, 0, 0,            1, 32'hfffffffc);
    add(1, 0, 0,            1, 32'hfffffffc, 1, 32'h00000000);
    add(1, 0, 0,            1, 32'h00000000, 1, 32'h00000004);
    @(negedge clk);
    chk("reset valid", bus_i.if_to_id_valid, 0);
    chk("reset sram_en", bus_i.inst_sram_en, 0);
    chk("sram_we", bus_i.inst_sram_we, 0);
    chk("sram_wdata", bus_i.inst_sram_wdata, 0);
    foreach (vt[i]) begin
      step(vt[i].al, vt[i].br, vt[i].tgt);
      chk($sformatf("row%0d valid", i), bus_i.if_to_id_valid, vt[i].v);
      if (vt[i].v) begin
        chk($sformatf("row%0d pc", i), bus_i.if_to_id_bus[31:0], vt[i].pc);
        chk($sformatf("row%0d inst", i), bus_i.if_to_id_bus[63:32], mem(vt[i].pc));
      end
      chk($sformatf("row%0d sram_en", i), bus_i.inst_sram_en, vt[i].en);
      if (vt[i].en) chk($sformatf("row%0d addr", i), bus_i.inst_sram_addr, vt[i].addr);
    end
    step(0, 0, 0);
    chk("stall pc", bus_i.if_to_id_bus[31:0], 32'h4);
    step(0, 0, 0);
    chk("stall inst", bus_i.if_to_id_bus[63:32], mem(32'h4));
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midreset valid", bus_i.if_to_id_valid, 0);
    chk("midreset sram_en", bus_i.inst_sram_en, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus_i.id_allowin = 1'b1;
    @(negedge clk);
    chk("rerelease addr", bus_i.inst_sram_addr, 32'h1c000000);
    chk("rerelease sram_en", bus_i.inst_sram_en, 1);
    chk("rerelease valid", bus_i.if_to_id_valid, 0);
    step(1, 0, 0);
    chk("refetch valid", bus_i.if_to_id_valid, 1);
    chk("refetch bus", bus_i.if_to_id_bus, {32'h02800421, 32'h1c000000});
    exp_pc = 32'h1c000004;
    for (int i = 0; i < 2000; i++) begin
      al = ($urandom % 4) != 0;
      br = ($urandom % 8) == 0;
      tgt = $urandom & 32'hfffffffc;
      step(al, br, tgt);
      chk("rnd valid", bus_i.if_to_id_valid, !br);
      if (!br) begin
        chk("rnd pc", bus_i.if_to_id_bus[31:0], exp_pc);
        chk("rnd inst", bus_i.if_to_id_bus[63:32], mem(exp_pc));
      end
      chk("rnd sram_en", bus_i.inst_sram_en, al | br);
      if (al | br) chk("rnd addr", bus_i.inst_sram_addr, br ? tgt : exp_pc + 32'd4);
`ifdef IF_ADEF_EN
      chk("rnd adef", bus_i.if_adef, 0);
`endif
      if (br) exp_pc = tgt;
      else if (al) exp_pc = exp_pc + 32'd4;
    end
`ifdef IF_ADEF_EN
    step(1, 1, 32'h1c000102);
    chk("adef sram_en", bus_i.inst_sram_en, 0);
    step(1, 0, 0);
    chk("adef valid", bus_i.if_to_id_valid, 1);
    chk("adef flag", bus_i.if_adef, 1);
    chk("adef bus", bus_i.if_to_id_bus, {32'h0, 32'h1c000102});
    step(1, 1, 32'h1c000200);
    step(1, 0, 0);
    chk("adef clear", bus_i.if_adef, 0);
    chk("adef recover", bus_i.if_to_id_bus, {mem(32'h1c000200), 32'h1c000200});
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
